// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and
// registers the returned word into the IF/ID pipeline register.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic [INST_W-1:0] inst_i,
    output logic              ce_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    // Redirect captured while the front end was stalled, replayed after the delay slot.
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_o        <= 1'b0;
            pc_o        <= align(RESET_PC);
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            ce_o <= 1'b1;
            if (ce_o) begin
                if (flush) begin
                    pc_o       <= align(flush_pc);
                    pend_valid <= 1'b0;
                end else if (stall_if) begin
                    if (branch_flag) begin
                        pend_valid  <= 1'b1;
                        pend_target <= align(branch_target);
                    end
                end else if (branch_flag) begin
                    pc_o       <= align(branch_target);
                    pend_valid <= 1'b0;
                end else if (pend_valid) begin
                    pc_o       <= pend_target;
                    pend_valid <= 1'b0;
                end else begin
                    pc_o <= pc_o + ADDR_W'(4);
                end
            end
        end
    end

    // IF/ID register: the word at pc_o is always captured on an unstalled edge,
    // which is what makes the fetch in the branch cycle the delay slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_o    <= '0;
            id_inst_o  <= '0;
            id_valid_o <= 1'b0;
        end else if (flush) begin
            id_inst_o  <= '0;
            id_valid_o <= 1'b0;
        end else if (stall_if) begin
            if (!stall_id) begin
                id_inst_o  <= '0;
                id_valid_o <= 1'b0;
            end
        end else begin
            id_pc_o    <= pc_o;
            id_inst_o  <= inst_i;
            id_valid_o <= ce_o;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model of the fetch rules.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] inst_i;
    logic        ce_o;
    logic [31:0] pc_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic        m_ce;
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend_t;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;

    inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .inst_i       (inst_i),
        .ce_o         (ce_o),
        .pc_o         (pc_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_valid_o   (id_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory contents as a pure function of the address
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h3401_1100;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign inst_i = mem(pc_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ce = 1'b0; m_pc = 32'h0; m_pend_v = 1'b0; m_pend_t = 32'h0;
        m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
    endtask

    // one rising edge of the fetch stage, computed from the behavioural rules
    task automatic model_edge();
        logic [31:0] word_addr_mask = 32'hFFFF_FFFC;
        if (flush) begin
            m_id_inst = 0; m_id_valid = 0;
        end else if (stall_if && !stall_id) begin
            m_id_inst = 0; m_id_valid = 0;
        end else if (!stall_if) begin
            m_id_pc = m_pc; m_id_inst = mem(m_pc); m_id_valid = m_ce;
        end
        if (m_ce) begin
            if (flush) begin
                m_pc = flush_pc & word_addr_mask; m_pend_v = 0;
            end else if (stall_if) begin
                if (branch_flag) begin
                    m_pend_v = 1; m_pend_t = branch_target & word_addr_mask;
                end
            end else if (branch_flag) begin
                m_pc = branch_target & word_addr_mask; m_pend_v = 0;
            end else if (m_pend_v) begin
                m_pc = m_pend_t; m_pend_v = 0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ce"},       {31'b0, ce_o},       {31'b0, m_ce});
        check({tag, ".pc"},       pc_o,                m_pc);
        check({tag, ".id_pc"},    id_pc_o,             m_id_pc);
        check({tag, ".id_inst"},  id_inst_o,           m_id_inst);
        check({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, m_id_valid});
    endtask

    task automatic set_in(input logic sif, input logic sid, input logic br,
                          input logic [31:0] bt, input logic fl, input logic [31:0] fp);
        stall_if = sif; stall_id = sid; branch_flag = br;
        branch_target = bt; flush = fl; flush_pc = fp;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // sequential run from reset
        step("seq0");
        check("seq0.pc_held", pc_o, 32'h0);
        step("seq1");
        check("seq1.first_inst", id_inst_o, 32'h3401_1100);
        check("seq1.first_valid", {31'b0, id_valid_o}, 32'h1);
        step("seq2");
        check("seq2.pc", pc_o, 32'h8);

        // full stall then bubble
        set_in(1, 1, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("hold");
        check("hold.pc", pc_o, 32'h8);
        check("hold.id_pc", id_pc_o, 32'h4);
        set_in(1, 0, 0, 32'h0, 0, 32'h0);
        step("bubble");
        check("bubble.valid", {31'b0, id_valid_o}, 32'h0);
        check("bubble.inst", id_inst_o, 32'h0);

        // branch with delay slot, unaligned target
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        step("run0");
        step("run1");
        check("run1.pc", pc_o, 32'h10);
        set_in(0, 0, 1, 32'h0000_0103, 0, 32'h0);
        step("br");
        check("br.target", pc_o, 32'h100);
        check("br.delay_slot", id_pc_o, 32'h10);
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        step("br_next");
        check("br_next.pc", pc_o, 32'h104);

        // branch while stalled, later branch overwrites pending target
        set_in(0, 0, 1, 32'h20, 0, 32'h0);
        step("to20");
        set_in(1, 0, 1, 32'h300, 0, 32'h0);
        step("pend0");
        set_in(1, 0, 1, 32'h203, 0, 32'h0);
        step("pend1");
        check("pend1.pc", pc_o, 32'h20);
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        step("pend_rel");
        check("pend_rel.pc", pc_o, 32'h200);
        check("pend_rel.delay_slot", id_pc_o, 32'h20);

        // flush beats a simultaneous branch and clears the pending redirect
        set_in(1, 0, 1, 32'h40, 0, 32'h0);
        step("pend2");
        set_in(0, 0, 1, 32'h40, 1, 32'h180);
        step("flush");
        check("flush.pc", pc_o, 32'h180);
        check("flush.valid", {31'b0, id_valid_o}, 32'h0);
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        step("flush_next");
        check("flush_next.pc", pc_o, 32'h184);

        // wrap at the top of the address space
        set_in(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0);
        step("top");
        check("top.pc", pc_o, 32'hFFFF_FFFC);
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        step("wrap");
        check("wrap.pc", pc_o, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 5) == 0,
                   $urandom, $urandom_range(0, 15) == 0, $urandom);
            step("rand");
        end

        // asynchronous reset in the middle of a cycle
        set_in(0, 0, 0, 32'h0, 0, 32'h0);
        step("pre_rst");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("rst_seq0");
        check("rst_seq0.pc", pc_o, 32'h0);
        step("rst_seq1");
        check("rst_seq1.pc", pc_o, 32'h4);

        for (int i = 0; i < 200; i++) begin
            set_in($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                   $urandom, $urandom_range(0, 20) == 0, $urandom);
            step("rand2");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
